issue_ctrl: RTL

//  Front-end sequencer feeding the 20-bit instruction {op[19:15],RW[14:10],RA[9:5],RB[4:0]} to Data_Dependency.

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/hazard_detect.sv | 27 ++
 rtl/issue_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// isa_pkg
//   Shared instruction-set definitions for the issue front end and Data_Dependency.
//   Instruction word layout: {op[19:15], rw[14:10], ra[9:5], rb[4:0]}.
//   Provides opcodes, field slice positions, the NOP word, the sequencer state
//   encoding and small field-extraction helpers.
package isa_pkg;

  localparam int INS_W = 20;

  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_ST  = 5'b10101;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_HLT = 5'b11110;
  localparam logic [4:0] OP_NOP = 5'b11111;

  localparam int OP_HI = 19;
  localparam int OP_LO = 15;
  localparam int RW_HI = 14;
  localparam int RW_LO = 10;
  localparam int RA_HI = 9;
  localparam int RA_LO = 5;
  localparam int RB_HI = 4;
  localparam int RB_LO = 0;

  localparam logic [INS_W-1:0] INS_NOP = {OP_NOP, 15'b0};

  // Sequencer state encoding, kept as plain constants so older tools that
  // share this package with Data_Dependency can read it unchanged.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [4:0] ins_op(input logic [INS_W-1:0] ins);
    return ins[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] ins_rw(input logic [INS_W-1:0] ins);
    return ins[RW_HI:RW_LO];
  endfunction

  function automatic logic [4:0] ins_ra(input logic [INS_W-1:0] ins);
    return ins[RA_HI:RA_LO];
  endfunction

  function automatic logic [4:0] ins_rb(input logic [INS_W-1:0] ins);
    return ins[RB_HI:RB_LO];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
//   Combinational load-use detector. Flags the case where the instruction now
//   on ins_out is a load whose destination is a source of the word arriving on
//   ins_in; forwarding cannot cover that, so the sequencer must insert a bubble.
// Ports
//   ins_out   in   20  instruction currently issued downstream
//   ins_vld   in   1   ins_out is a real instruction
//   ins_in    in   20  word just read from the instruction ROM
//   load_use  out  1   bubble required this cycle
module hazard_detect
  import isa_pkg::*;
(
  input  logic [INS_W-1:0] ins_out,
  input  logic             ins_vld,
  input  logic [INS_W-1:0] ins_in,
  output logic             load_use
);

  logic is_load;
  logic src_hit;

  assign is_load  = ins_vld && (ins_op(ins_out) == OP_LD);
  assign src_hit  = (ins_ra(ins_in) == ins_rw(ins_out)) ||
                    (ins_rb(ins_in) == ins_rw(ins_out));
  assign load_use = is_load && src_hit;

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl
//   Front-end sequencer: owns the PC, drives a synchronous-read instruction ROM,
//   issues words to Data_Dependency, inserts one bubble on load-use hazards and
//   executes JMP/HLT locally. After HLT it issues DRAIN_CYC NOPs then parks in DONE.
// Ports
//   clk       in   1       rising-edge clock
//   reset     in   1       synchronous, active-low
//   start     in   1       begin fetching at address 0 (IDLE/DONE only)
//   hold      in   1       external freeze
//   rom_addr  out  ADDR_W  ROM read address (data on ins_in next cycle)
//   ins_in    in   20      ROM data for previous cycle's rom_addr
//   ins_out   out  20      registered instruction to Data_Dependency
//   ins_vld   out  1       ins_out is a real instruction (else NOP)
//   stall     out  1       registered; high in a cycle carrying a load-use bubble
//   busy      out  1       state is FILL/RUN/FLUSH/DRAIN
//   done      out  1       state is DONE
module issue_ctrl
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INS_W-1:0]  ins_in,
  output logic [INS_W-1:0]  ins_out,
  output logic              ins_vld,
  output logic              stall,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fpc;
  logic [CNT_W-1:0]  cnt;

  logic              load_use;
  logic              run_live;
  logic              do_stall;
  logic              do_jmp;
  logic              replay;
  logic [ADDR_W-1:0] jmp_tgt;

  hazard_detect u_hazard (
    .ins_out  (ins_out),
    .ins_vld  (ins_vld),
    .ins_in   (ins_in),
    .load_use (load_use)
  );

  // A jump redirects the fetch in the same cycle it is decoded; replay
  // re-reads the word already on ins_in so it arrives again next cycle.
  assign run_live = (state == ST_RUN) && !hold;
  assign do_stall = run_live && load_use;
  assign do_jmp   = run_live && !load_use && (ins_op(ins_in) == OP_JMP);
  assign jmp_tgt  = ins_in[ADDR_W-1:0];
  assign replay   = do_stall || hold || (state == ST_FLUSH);
  assign rom_addr = do_jmp ? jmp_tgt : (replay ? fpc : pc);

  assign busy = (state == ST_FILL) || (state == ST_RUN) ||
                (state == ST_FLUSH) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // Every cycle defaults to issuing a NOP; only a plain instruction decoded
  // in RUN overrides it. fpc always tracks the address just requested so it
  // names the word that will sit on ins_in next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      fpc     <= '0;
      cnt     <= '0;
      ins_out <= INS_NOP;
      ins_vld <= 1'b0;
      stall   <= 1'b0;
    end else begin
      ins_out <= INS_NOP;
      ins_vld <= 1'b0;
      stall   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_FILL;
            pc    <= '0;
            fpc   <= '0;
          end
        end
        ST_FILL: begin
          if (!hold) begin
            state <= ST_RUN;
            pc    <= pc + ADDR_ONE;
            fpc   <= rom_addr;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            fpc <= rom_addr;
            if (load_use) begin
              stall <= 1'b1;
            end else if (ins_op(ins_in) == OP_JMP) begin
              pc    <= jmp_tgt + ADDR_ONE;
              state <= ST_FLUSH;
            end else if (ins_op(ins_in) == OP_HLT) begin
              // The NOP issued for HLT itself is the first drain cycle.
              cnt   <= CNT_ONE;
              state <= (DRAIN_CYC <= 1) ? ST_DONE : ST_DRAIN;
            end else begin
              ins_out <= ins_in;
              ins_vld <= 1'b1;
              pc      <= pc + ADDR_ONE;
            end
          end
        end
        ST_FLUSH: begin
          if (!hold) begin
            state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!hold) begin
            if (cnt == CNT_LAST) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
